// File: rtl/clip_timer_addr_gen.sv
// Clip timer and clip-memory address generator.
// A clip starts when timer rises while IDLE: the block/write selection is
// latched, and samples are paced every CLKS_PER_SAMPLE clocks. Each sample slot
// produces one strobe with its address. seconds2 pulses once after the last
// sample. The clip aborts at once if timer drops.
module clip_timer_addr_gen #(
  parameter int unsigned CLKS_PER_SAMPLE  = 12500,
  parameter int unsigned SAMPLES_PER_CLIP = 16000,
  parameter int unsigned OFFSET_W         = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                timer,
  input  logic [1:0]          memoryselect_clip_1,
  output logic                seconds2,
  output logic                sample_strobe,
  output logic [OFFSET_W:0]   mem_addr,
  output logic                mem_we,
  output logic                busy
);

  localparam int unsigned PRESC_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [OFFSET_W-1:0] OFF_LAST   = OFFSET_W'(SAMPLES_PER_CLIP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic                  blk_q, blk_d;
  logic                  wr_q, wr_d;
  logic                  strobe_q, strobe_d;
  logic                  sec2_q, sec2_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic [OFFSET_W:0]     addr_q, addr_d;

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      offset_q <= '0;
      blk_q    <= 1'b0;
      wr_q     <= 1'b0;
      strobe_q <= 1'b0;
      sec2_q   <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      offset_q <= offset_d;
      blk_q    <= blk_d;
      wr_q     <= wr_d;
      strobe_q <= strobe_d;
      sec2_q   <= sec2_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic, sample pacing and output generation.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    offset_d = offset_q;
    blk_d    = blk_q;
    wr_d     = wr_q;
    strobe_d = 1'b0;
    sec2_d   = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (timer) begin
          blk_d    = memoryselect_clip_1[1];
          wr_d     = memoryselect_clip_1[0];
          presc_d  = '0;
          offset_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!timer) begin
          // Abort takes priority, even over completion on the last strobe.
          state_d = S_IDLE;
        end else begin
          // A strobe cycle never coincides with the prescaler's last count
          // (CLKS_PER_SAMPLE >= 2), so offset_q is stable when a strobe is
          // issued.
          if (strobe_q) begin
            if (offset_q == OFF_LAST) begin
              state_d = S_DONE;
              sec2_d  = 1'b1;
            end else begin
              offset_d = offset_q + 1'b1;
            end
          end
          if (presc_q == PRESC_LAST) begin
            presc_d  = '0;
            strobe_d = 1'b1;
            we_d     = wr_q;
            addr_d   = {blk_q, offset_q};
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!timer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign seconds2      = sec2_q;
  assign sample_strobe = strobe_q;
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_clip_timer_addr_gen.sv
// Testbench for clip_timer_addr_gen: the stimulus side predicts each strobe
// and seconds2 pulse from the clip timing rules and queues them. A monitor
// matches the DUT's pulses against that queue.
module tb_clip_timer_addr_gen;

  localparam int CPS = 4;
  localparam int SPC = 5;
  localparam int OW  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          timer;
  logic [1:0]    msel;
  logic          seconds2;
  logic          sample_strobe;
  logic [OW:0]   mem_addr;
  logic          mem_we;
  logic          busy;

  clip_timer_addr_gen #(
    .CLKS_PER_SAMPLE (CPS),
    .SAMPLES_PER_CLIP(SPC),
    .OFFSET_W        (OW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .timer              (timer),
    .memoryselect_clip_1(msel),
    .seconds2           (seconds2),
    .sample_strobe      (sample_strobe),
    .mem_addr           (mem_addr),
    .mem_we             (mem_we),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  // Edge counter: edge n is the rising edge after which cyc == n.
  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    int          at;
    bit          kind;   // 0 = sample strobe, 1 = seconds2
    logic [OW:0] addr;
    logic        we;
  } ev_t;

  ev_t q[$];
  int  tests   = 0;
  int  fails   = 0;
  int  busy_lo = 1;
  int  busy_hi = 0;
  bit  mon_en  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: match every DUT pulse against the expected-event queue.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_%s at cycle %0d: got nothing required pulse",
                 q[0].kind ? "seconds2" : "strobe", q[0].at);
        void'(q.pop_front());
      end
      if (sample_strobe) begin
        if (q.size() > 0 && q[0].at == cyc && q[0].kind == 1'b0) begin
          chk("strobe_addr", mem_addr, q[0].addr);
          chk("strobe_we", mem_we, q[0].we);
          void'(q.pop_front());
        end else begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe at cycle %0d: got 1 required 0", cyc);
        end
      end
      if (seconds2) begin
        if (q.size() > 0 && q[0].at == cyc && q[0].kind == 1'b1) begin
          tests++;
          void'(q.pop_front());
        end else begin
          tests++;
          fails++;
          $display("FAIL unexpected_seconds2 at cycle %0d: got 1 required 0", cyc);
        end
      end
      if (!sample_strobe) chk("we_without_strobe", mem_we, 0);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  // Hold timer high for L edges starting at the next edge, then low for two.
  task automatic run_clip(input logic [1:0] ms, input int len, input bit toggle);
    int t0;
    ev_t e;
    timer = 1'b1;
    msel  = ms;
    t0    = cyc + 1;
    for (int k = 0; k < SPC; k++) begin
      if (CPS * (k + 1) <= len - 1) begin
        e.at   = t0 + CPS * (k + 1);
        e.kind = 1'b0;
        e.addr = {ms[1], OW'(k)};
        e.we   = ms[0];
        q.push_back(e);
      end
    end
    if (CPS * SPC + 1 <= len - 1) begin
      e.at   = t0 + CPS * SPC + 1;
      e.kind = 1'b1;
      e.addr = '0;
      e.we   = 1'b0;
      q.push_back(e);
    end
    busy_lo = t0;
    busy_hi = (len - 1 < CPS * SPC) ? t0 + len - 1 : t0 + CPS * SPC;
    @(posedge clock);
    #1;
    if (toggle) msel = 2'($urandom);
    repeat (len - 1) @(posedge clock);
    #1;
    timer = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    timer = 1'b0;
    msel  = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_strobe", sample_strobe, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_seconds2", seconds2, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    run_clip(2'b01, CPS * SPC + 2, 1'b0);        // write block 0
    run_clip(2'b01, CPS * SPC + 2, 1'b1);        // select changes mid-clip
    run_clip(2'b10, CPS * SPC + 2, 1'b0);        // read block 1
    run_clip(2'b11, 2 * CPS + 1, 1'b0);          // abort right after 2nd strobe
    run_clip(2'b01, CPS * SPC + 2, 1'b0);        // restart from offset 0
    run_clip(2'b01, CPS * SPC + 1, 1'b0);        // abort on last-strobe edge
    run_clip(2'b11, CPS * SPC + 2 + 40, 1'b0);   // timer held after completion
    run_clip(2'b10, CPS * SPC + 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_clip(2'($urandom), int'($urandom_range(1, CPS * SPC + 10)), 1'($urandom));
    end

    // Asynchronous reset between edges while a strobe is on the outputs.
    mon_en = 1'b0;
    timer  = 1'b1;
    msel   = 2'b01;
    repeat (CPS + 1) @(posedge clock);
    #1;
    chk("pre_reset_strobe", sample_strobe, 1);
    chk("pre_reset_busy", busy, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_strobe", sample_strobe, 0);
    chk("async_we", mem_we, 0);
    chk("async_seconds2", seconds2, 0);
    chk("async_addr", mem_addr, 0);
    timer = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    busy_lo = 1;
    busy_hi = 0;
    mon_en  = 1'b1;
    run_clip(2'b11, CPS * SPC + 2, 1'b0);

    repeat (10) @(posedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
